// File: rtl/bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_serial_subtractor
//  Description : Digit-serial BCD subtractor. Computes |a - b| and its sign
//                one decimal digit per clock, least-significant digit first,
//                with a borrow chain. Sign-magnitude BCD result is returned
//                over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] diff,
    output logic                sign,
    output logic                err
);

    // Digit index width; a one-digit build still needs a 1-bit index.
    localparam int              c_IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(DIGITS - 1);
    localparam logic [c_IW-1:0] c_ONE  = c_IW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [4*DIGITS-1:0]   r_a;
    logic [4*DIGITS-1:0]   r_b;
    logic [4*DIGITS-1:0]   r_res;
    logic                  r_sign;
    logic                  r_err;
    logic                  r_borrow;
    logic [c_IW-1:0]       r_idx;

    logic [4*DIGITS-1:0]   w_a_nxt;
    logic [4*DIGITS-1:0]   w_b_nxt;
    logic [4*DIGITS-1:0]   w_res_nxt;
    logic                  w_sign_nxt;
    logic                  w_err_nxt;
    logic                  w_borrow_nxt;
    logic [c_IW-1:0]       w_idx_nxt;

    logic [DIGITS-1:0]     w_dig_bad;
    logic                  w_bad;
    logic [c_IW+1:0]       w_pos;
    logic [3:0]            w_min;
    logic [3:0]            w_sub;
    logic [4:0]            w_t;
    logic                  w_neg;
    logic [3:0]            w_dig;

    // Flag any non-decimal nibble on either incoming operand.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_chk
            assign w_dig_bad[gi] = (a[gi*4 +: 4] > 4'd9) || (b[gi*4 +: 4] > 4'd9);
        end
    endgenerate
    assign w_bad = |w_dig_bad;

    // Shared single-digit subtract stage. In FIX the minuend is zero and the
    // subtrahend is the raw ten's-complement digit, which turns the raw result
    // into its magnitude with the same borrow/correction rule as SUB.
    assign w_pos = {r_idx, 2'b00};
    assign w_min = (r_state == S_FIX) ? 4'd0 : r_a[w_pos +: 4];
    assign w_sub = (r_state == S_FIX) ? r_res[w_pos +: 4] : r_b[w_pos +: 4];
    assign w_t   = {1'b0, w_min} - {1'b0, w_sub} - {4'b0000, r_borrow};
    assign w_neg = w_t[4];
    assign w_dig = w_neg ? (w_t[3:0] + 4'd10) : w_t[3:0];

    // Handshake and result outputs; in_ready is forced low while reset is held.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = (r_state == S_DONE);
    assign diff      = r_res;
    assign sign      = r_sign;
    assign err       = r_err;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update decisions.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_res_nxt    = r_res;
        w_sign_nxt   = r_sign;
        w_err_nxt    = r_err;
        w_borrow_nxt = r_borrow;
        w_idx_nxt    = r_idx;

        case (r_state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    w_a_nxt      = a;
                    w_b_nxt      = b;
                    w_res_nxt    = '0;
                    w_sign_nxt   = 1'b0;
                    w_err_nxt    = w_bad;
                    w_borrow_nxt = 1'b0;
                    w_idx_nxt    = '0;
                    w_state_nxt  = S_SUB;
                end
            end

            S_SUB: begin
                // A bad operand spends exactly one cycle here with a zero result.
                if (r_err) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_res_nxt[w_pos +: 4] = w_dig;
                    w_borrow_nxt          = w_neg;
                    if (r_idx == c_LAST) begin
                        w_idx_nxt = '0;
                        if (w_neg) begin
                            // Borrow out of the top digit: raw result is the
                            // ten's complement of the magnitude.
                            w_sign_nxt   = 1'b1;
                            w_borrow_nxt = 1'b0;
                            w_state_nxt  = S_FIX;
                        end else begin
                            w_state_nxt  = S_DONE;
                        end
                    end else begin
                        w_idx_nxt = r_idx + c_ONE;
                    end
                end
            end

            S_FIX: begin
                w_res_nxt[w_pos +: 4] = w_dig;
                w_borrow_nxt          = w_neg;
                if (r_idx == c_LAST) begin
                    w_idx_nxt    = '0;
                    w_borrow_nxt = 1'b0;
                    w_state_nxt  = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + c_ONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand, result and borrow-chain registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_sign   <= 1'b0;
            r_err    <= 1'b0;
            r_borrow <= 1'b0;
            r_idx    <= '0;
        end else begin
            r_a      <= w_a_nxt;
            r_b      <= w_b_nxt;
            r_res    <= w_res_nxt;
            r_sign   <= w_sign_nxt;
            r_err    <= w_err_nxt;
            r_borrow <= w_borrow_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_serial_subtractor
//  Description : Self-checking bench for bcd_serial_subtractor (DIGITS=4).
//                Integer-arithmetic reference model checked every cycle, plus
//                directed vectors with hand-computed results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_serial_subtractor;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] diff;
    logic         sign;
    logic         err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .sign      (sign),
        .err       (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain decimal arithmetic) -----------
    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 0; i < D; i++)
            if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_res(input logic [W-1:0] x, input logic [W-1:0] y);
        int d;
        if (has_bad(x, y)) return '0;
        d = bcd2int(x) - bcd2int(y);
        return int2bcd(d < 0 ? -d : d);
    endfunction

    function automatic bit m_neg(input logic [W-1:0] x, input logic [W-1:0] y);
        if (has_bad(x, y)) return 1'b0;
        return bcd2int(x) < bcd2int(y);
    endfunction

    function automatic int m_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        if (has_bad(x, y)) return 1;
        return (bcd2int(x) < bcd2int(y)) ? 2 * D : D;
    endfunction

    logic         m_idle  = 1'b1;
    logic         m_valid = 1'b0;
    logic [W-1:0] m_diff  = '0;
    logic         m_sign  = 1'b0;
    logic         m_err   = 1'b0;
    int           m_cnt   = 0;

    // Model advances on the same edge as the DUT, from pre-edge inputs.
    always @(posedge clk) begin
        if (rst) begin
            m_idle  <= 1'b1;
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_diff  <= '0;
            m_sign  <= 1'b0;
            m_err   <= 1'b0;
        end else if (m_idle) begin
            if (in_valid) begin
                m_idle <= 1'b0;
                m_cnt  <= m_lat(a, b);
                m_diff <= m_res(a, b);
                m_sign <= m_neg(a, b);
                m_err  <= has_bad(a, b);
            end
        end else if (m_cnt > 0) begin
            m_cnt   <= m_cnt - 1;
            m_valid <= (m_cnt == 1);
        end else if (m_valid && out_ready) begin
            m_valid <= 1'b0;
            m_idle  <= 1'b1;
        end
    end

    // Compare process: every cycle, shortly after the edge.
    always @(posedge clk) begin
        #2;
        chk("in_ready", 32'(in_ready), 32'(m_idle && !rst));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_idle || m_valid) begin
            chk("diff", 32'(diff), 32'(m_diff));
            chk("sign", 32'(sign), 32'(m_sign));
            chk("err", 32'(err), 32'(m_err));
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Called at the negedge after the accept edge; returns cycles to out_valid.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic [W-1:0] ed, input logic es, input logic ee,
                          input int el);
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        a = ta;
        b = tb;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_out(lat);
        chk("latency", 32'(lat), 32'(el));
        chk("lit_diff", 32'(diff), 32'(ed));
        chk("lit_sign", 32'(sign), 32'(es));
        chk("lit_err", 32'(err), 32'(ee));
        @(posedge clk);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        run_op(16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 4);
        run_op(16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 8);
        run_op(16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 8);
        run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 4);
        run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0, 4);
        run_op(16'h00A0, 16'h0001, 16'h0000, 1'b0, 1'b1, 1);
        run_op(16'h0050, 16'h0025, 16'h0025, 1'b0, 1'b0, 4);
        run_op(16'h0000, 16'hF000, 16'h0000, 1'b0, 1'b1, 1);
        run_op(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 8);
        run_op(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 4);

        // Backpressure with a second operand pair waiting.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 16'h2500;
        b = 16'h0700;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        a = 16'h0003;
        b = 16'h0008;
        wait_out(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_diff", 32'(diff), 32'h1800);
            chk("bp_no_accept", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        chk("bp_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp2_latency", 32'(lat), 32'd8);
        chk("bp2_diff", 32'(diff), 32'h0005);
        chk("bp2_sign", 32'(sign), 32'd1);
        @(posedge clk);

        // Reset while correcting a negative result.
        @(negedge clk);
        in_valid = 1'b1;
        a = 16'h0001;
        b = 16'h0002;
        wait_ready();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_sign", 32'(sign), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        run_op(16'h0009, 16'h0003, 16'h0006, 1'b0, 1'b0, 4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bcd_serial_subtractor.md
# bcd_serial_subtractor

Multi-digit BCD subtractor that computes |A − B| and its sign one decimal digit per clock, least-significant digit first, with a borrow chain across digits. It sits directly above the single-digit BCD subtraction stage in the arithmetic datapath. It accepts packed N-digit operands through a valid/ready handshake and returns a sign-magnitude BCD result through a second valid/ready handshake.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a/b valid.
- in_ready  out  1  block can accept operands.
- a  in  4*DIGITS  minuend, packed BCD, digit 0 in a[3:0].
- b  in  4*DIGITS  subtrahend, packed BCD.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- diff  out  4*DIGITS  magnitude |a − b|, packed BCD.
- sign  out  1  1 = result negative (a < b).
- err  out  1  an input digit was > 9.

## Operation
- Decided: one clock, `clk`; reset `rst` is synchronous and active-high.
- States: IDLE, SUB, FIX, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, register a and b, clear the borrow, clear the digit index, and check every digit.
  - If any digit of a or b is > 9: go to DONE with diff = 0, sign = 0, err = 1.
  - Otherwise: go to SUB.
- SUB: per cycle, process digit i: t = a_i − b_i − borrow.
  - If t < 0: store t + 10 and set borrow = 1.
  - Else: store t and set borrow = 0.
  - After digit DIGITS−1:
    - Final borrow = 0: go to DONE, sign = 0.
    - Final borrow = 1: the raw result is the ten's complement. Set sign = 1, clear the borrow and index, go to FIX.
- FIX: per cycle, replace digit i with 0 − raw_i − borrow, using the same correction rule as SUB. This yields 10^DIGITS − raw = the magnitude. After the last digit, go to DONE.
- DONE: out_valid = 1; diff, sign and err are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- Zero result (a == b): diff = 0, sign = 0. Negative zero never occurs.
- Every digit of diff is always within 0–9.
- in_ready is 0 in SUB, FIX and DONE. Operands presented then are ignored and need not be held.
- There is no bypass: a new operand pair is accepted no earlier than the cycle after the output handshake.

## Timing
- Reset values: in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts. out_valid = 0, diff = 0, sign = 0, err = 0; state = IDLE.
- Reset mid-operation (SUB, FIX or DONE): the operation is aborted, with no output handshake. All outputs return to their reset values on the next edge.
- Accept edge E0. Digit i of SUB is processed on edge E(i+1).
- Latency from the accept edge to out_valid high:
  - Non-negative result: DIGITS cycles (out_valid visible after edge E(DIGITS)).
  - Negative result: 2·DIGITS cycles.
  - Input error: 1 cycle.
- out_valid stays high, and diff/sign/err are unchanged, for every cycle in which out_ready = 0.
- Result handshake at edge H: out_valid = 0 and in_ready = 1 from edge H onward.
- diff, sign and err keep their last values after the handshake until the next operation updates them. They are not qualified without out_valid.

## Test plan
- DIGITS=4, a=0x5432, b=0x1234, out_ready=1 → out_valid 4 cycles after accept, diff=0x4198, sign=0, err=0; in_ready=0 for cycles 1–4.
- a=0x1234, b=0x5432 → out_valid 8 cycles after accept, diff=0x4198, sign=1. Also a=0x0000, b=0x0001 → diff=0x0001, sign=1.
- Borrow ripple: a=0x1000, b=0x0001 → diff=0x0999, sign=0. Equal operands a=b=0x9999 → diff=0x0000, sign=0.
- Invalid digit: a=0x00A0, b=0x0001 → out_valid 1 cycle after accept, diff=0, sign=0, err=1. The next valid operation returns err=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, with in_valid=1 and new operands → outputs stable, no second accept. Raise out_ready → handshake, in_ready=1 next cycle, new pair accepted.
- Reset during FIX (a=0x0001, b=0x0002, rst on cycle 6) → next cycle out_valid=0, diff=0, sign=0, err=0. in_ready=1 after rst drops; a following 0x0009 − 0x0003 gives diff=0x0006, sign=0.
